// File: rtl/snake_body_engine.sv
// -----------------------------------------------------------------------------
// snake_body_engine
//
// Owns the snake's segment coordinates (in grid tiles) plus the food and
// collision state, and publishes the segments in the packed form the VGA
// renderer reads. Each accepted movement tick advances the snake by one tile,
// grows it when the head lands on the food, and ends the game on a wall or
// self hit.
//
// Ports:
//   clk         system clock (single domain)
//   reset       synchronous, active-low reset
//   step_tick   one-cycle move request, honoured only in IDLE
//   dir_in      requested direction: 0 up, 1 right, 2 down, 3 left
//   dir_valid   qualifies dir_in (latched in any state, reversals rejected)
//   food_x/y    food tile, sampled when a step is accepted
//   x_values    segment x, segment k at [32k+31:32k], unused = 32'hFFFFFFFF
//   y_values    segment y, same packing
//   length      number of live segments
//   game_done   sticky end-of-game flag
//   food_eaten  one-cycle pulse when the head lands on the food
//   busy        high while a step is being checked/applied
//   state_dbg   current FSM state (IDLE=0, CHECK=1, UPDATE=2, DONE=3)
//
// Handshake: step_tick is a fire-and-forget request; it is accepted only on
// an edge where the FSM is in IDLE and is silently dropped otherwise. busy
// reports that an accepted step has not yet been retired.
// -----------------------------------------------------------------------------
module snake_body_engine #(
    parameter int GRID_W  = 10,
    parameter int GRID_H  = 10,
    parameter int MAX_LEN = 100,
    parameter int INIT_X  = 4,
    parameter int INIT_Y  = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    step_tick,
    input  logic [1:0]              dir_in,
    input  logic                    dir_valid,
    input  logic [31:0]             food_x,
    input  logic [31:0]             food_y,
    output logic [32*MAX_LEN-1:0]   x_values,
    output logic [32*MAX_LEN-1:0]   y_values,
    output logic [7:0]              length,
    output logic                    game_done,
    output logic                    food_eaten,
    output logic                    busy,
    output logic [1:0]              state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        UPDATE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;
    localparam int         IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    state_t      state;
    state_t      state_next;

    logic [31:0] seg_x [MAX_LEN];
    logic [31:0] seg_y [MAX_LEN];

    logic [1:0]  cur_dir;
    logic [1:0]  pend_dir;
    logic [1:0]  eff_dir;
    logic        dir_ok;

    logic [31:0] next_x;
    logic [31:0] next_y;
    logic        wall_hit;
    logic        next_eat;
    logic        next_grow;

    logic [31:0] cand_x;
    logic [31:0] cand_y;
    logic        eat_r;
    logic        grow_r;
    logic [7:0]  limit_r;
    logic [7:0]  k;
    logic        seg_hit;

    // Packed views for the renderer; slots beyond length already hold all-ones.
    for (genvar g = 0; g < MAX_LEN; g++) begin : g_pack
        assign x_values[32*g +: 32] = seg_x[g];
        assign y_values[32*g +: 32] = seg_y[g];
    end

    assign state_dbg = state;

    // Opposite directions differ only in bit 1, so a reversal is cur ^ 2.
    // A same-edge valid direction takes effect for a step on that edge.
    always_comb begin
        dir_ok  = dir_valid && (dir_in != (cur_dir ^ 2'd2));
        eff_dir = dir_ok ? dir_in : pend_dir;
    end

    // Candidate head; the wall test is done before any subtraction so no
    // coordinate ever underflows.
    always_comb begin
        next_x   = seg_x[0];
        next_y   = seg_y[0];
        wall_hit = 1'b0;
        case (eff_dir)
            DIR_UP: begin
                if (seg_y[0] == 32'd0) wall_hit = 1'b1;
                else                   next_y   = seg_y[0] - 32'd1;
            end
            DIR_RIGHT: begin
                if (seg_x[0] + 32'd1 == 32'(GRID_W)) wall_hit = 1'b1;
                else                                  next_x   = seg_x[0] + 32'd1;
            end
            DIR_DOWN: begin
                if (seg_y[0] + 32'd1 == 32'(GRID_H)) wall_hit = 1'b1;
                else                                  next_y   = seg_y[0] + 32'd1;
            end
            default: begin
                if (seg_x[0] == 32'd0) wall_hit = 1'b1;
                else                   next_x   = seg_x[0] - 32'd1;
            end
        endcase
        next_eat  = (next_x == food_x) && (next_y == food_y);
        next_grow = next_eat && (length < 8'(MAX_LEN));
    end

    assign seg_hit = (cand_x == seg_x[k[IDX_W-1:0]]) && (cand_y == seg_y[k[IDX_W-1:0]]);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (step_tick) state_next = wall_hit ? DONE : CHECK;
            end
            CHECK: begin
                if (seg_hit)                     state_next = DONE;
                else if (k == limit_r - 8'd1)    state_next = UPDATE;
            end
            UPDATE:  state_next = IDLE;
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= '1;
                seg_y[i] <= '1;
            end
            seg_x[0]   <= 32'(INIT_X);
            seg_x[1]   <= 32'(INIT_X - 1);
            seg_x[2]   <= 32'(INIT_X - 2);
            seg_y[0]   <= 32'(INIT_Y);
            seg_y[1]   <= 32'(INIT_Y);
            seg_y[2]   <= 32'(INIT_Y);
            length     <= 8'd3;
            cur_dir    <= DIR_RIGHT;
            pend_dir   <= DIR_RIGHT;
            game_done  <= 1'b0;
            food_eaten <= 1'b0;
            busy       <= 1'b0;
            cand_x     <= '0;
            cand_y     <= '0;
            eat_r      <= 1'b0;
            grow_r     <= 1'b0;
            limit_r    <= '0;
            k          <= '0;
        end else begin
            food_eaten <= 1'b0;
            busy       <= (state_next == CHECK) || (state_next == UPDATE);
            if (dir_ok) pend_dir <= dir_in;

            // A self hit raises the flag on the edge entering DONE; a wall hit
            // enters DONE on the sampling edge and raises it one edge later.
            if (state == DONE || (state == CHECK && seg_hit)) game_done <= 1'b1;

            case (state)
                IDLE: begin
                    if (step_tick) begin
                        cur_dir  <= eff_dir;
                        pend_dir <= eff_dir;
                        cand_x   <= next_x;
                        cand_y   <= next_y;
                        eat_r    <= next_eat;
                        grow_r   <= next_grow;
                        // The tail tile is vacated this step unless growing.
                        limit_r  <= next_grow ? length : length - 8'd1;
                        k        <= '0;
                    end
                end
                CHECK: begin
                    if (!seg_hit) k <= k + 8'd1;
                end
                UPDATE: begin
                    for (int i = 1; i < MAX_LEN; i++) begin
                        if (i < int'(length) || (grow_r && i == int'(length))) begin
                            seg_x[i] <= seg_x[i-1];
                            seg_y[i] <= seg_y[i-1];
                        end
                    end
                    seg_x[0]   <= cand_x;
                    seg_y[0]   <= cand_y;
                    food_eaten <= eat_r;
                    if (grow_r) length <= length + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_snake_body_engine.sv
// -----------------------------------------------------------------------------
// Bench for snake_body_engine. A queue-based snake model predicts every step;
// the driver pushes the predicted outcome (expected cycle, flags, arrays) and
// an independent monitor pops it when the DUT retires a step.
// -----------------------------------------------------------------------------
module tb_snake_body_engine;

  localparam int GRID_W  = 10;
  localparam int GRID_H  = 10;
  localparam int MAX_LEN = 100;
  localparam int INIT_X  = 4;
  localparam int INIT_Y  = 5;
  localparam int AW      = 32 * MAX_LEN;
  localparam int EW      = 32 + 1 + 1 + 8 + 2 * AW;

  logic          clk;
  logic          reset;
  logic          step_tick;
  logic [1:0]    dir_in;
  logic          dir_valid;
  logic [31:0]   food_x;
  logic [31:0]   food_y;
  logic [AW-1:0] x_values;
  logic [AW-1:0] y_values;
  logic [7:0]    length;
  logic          game_done;
  logic          food_eaten;
  logic          busy;
  logic [1:0]    state_dbg;

  snake_body_engine #(
    .GRID_W(GRID_W), .GRID_H(GRID_H), .MAX_LEN(MAX_LEN),
    .INIT_X(INIT_X), .INIT_Y(INIT_Y)
  ) dut (
    .clk(clk), .reset(reset), .step_tick(step_tick), .dir_in(dir_in),
    .dir_valid(dir_valid), .food_x(food_x), .food_y(food_y),
    .x_values(x_values), .y_values(y_values), .length(length),
    .game_done(game_done), .food_eaten(food_eaten), .busy(busy),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  bit in_reset = 1'b1;

  logic [EW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic chk_arr(input string name, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      for (int i = 0; i < MAX_LEN; i++) begin
        if (got[32*i +: 32] !== exp[32*i +: 32]) begin
          $display("FAIL %s seg %0d got=%0h exp=%0h (cycle %0d)", name, i,
                   got[32*i +: 32], exp[32*i +: 32], cyc);
          break;
        end
      end
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mx[$];
  logic [31:0] my[$];
  logic [1:0]  m_cur;
  logic [1:0]  m_pend;
  bit          m_done;

  function automatic void model_reset();
    mx.delete(); my.delete();
    for (int i = 0; i < 3; i++) begin
      mx.push_back(32'(INIT_X - i));
      my.push_back(32'(INIT_Y));
    end
    m_cur  = 2'd1;
    m_pend = 2'd1;
    m_done = 1'b0;
  endfunction

  function automatic void model_dir(input logic [1:0] d);
    logic [1:0] opposite;
    opposite = m_cur + 2'd2;
    if (d != opposite) m_pend = d;
  endfunction

  function automatic logic [AW-1:0] pack_body(input bit is_y);
    logic [AW-1:0] v;
    v = '1;
    for (int i = 0; i < mx.size(); i++) v[32*i +: 32] = is_y ? my[i] : mx[i];
    return v;
  endfunction

  // Moves the model snake one step; returns the outcome and its latency.
  task automatic model_step(input logic [31:0] fx, input logic [31:0] fy,
                            output bit wall, output bit gd, output bit fe,
                            output int lat);
    logic [31:0] hx, hy, cx, cy;
    bit grow;
    int span, hit;
    m_cur = m_pend;
    hx = mx[0]; hy = my[0]; cx = hx; cy = hy;
    wall = 1'b0; gd = 1'b0; fe = 1'b0;
    case (m_cur)
      2'd0: if (hy == 0) wall = 1; else cy = hy - 1;
      2'd1: if (hx == GRID_W - 1) wall = 1; else cx = hx + 1;
      2'd2: if (hy == GRID_H - 1) wall = 1; else cy = hy + 1;
      default: if (hx == 0) wall = 1; else cx = hx - 1;
    endcase
    if (wall) begin
      m_done = 1'b1; gd = 1'b1; lat = 1;
      return;
    end
    grow = (cx == fx) && (cy == fy) && (mx.size() < MAX_LEN);
    span = grow ? mx.size() : mx.size() - 1;
    hit = -1;
    for (int j = 0; j < span; j++) begin
      if (mx[j] == cx && my[j] == cy) begin hit = j; break; end
    end
    if (hit >= 0) begin
      m_done = 1'b1; gd = 1'b1; lat = hit + 1;
      return;
    end
    mx.push_front(cx); my.push_front(cy);
    if (!grow) begin void'(mx.pop_back()); void'(my.pop_back()); end
    fe  = (cx == fx) && (cy == fy);
    lat = span + 1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic check_state(input string tag);
    chk({tag, "_length"}, 32'(length), 32'(mx.size()));
    chk({tag, "_game_done"}, 32'(game_done), 32'(m_done));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_food_eaten"}, 32'(food_eaten), 32'd0);
    chk_arr({tag, "_x"}, x_values, pack_body(1'b0));
    chk_arr({tag, "_y"}, y_values, pack_body(1'b1));
  endtask

  task automatic apply_reset(input string tag);
    in_reset  = 1'b1;
    step_tick = 1'b0;
    dir_valid = 1'b0;
    reset     = 1'b0;
    exp_q.delete();
    model_reset();
    @(negedge clk);
    check_state(tag);
    reset = 1'b1;
    @(negedge clk);
    in_reset = 1'b0;
  endtask

  task automatic drive_dir(input logic [1:0] d);
    @(negedge clk);
    dir_valid = 1'b1;
    dir_in    = d;
    model_dir(d);
    @(negedge clk);
    dir_valid = 1'b0;
  endtask

  task automatic do_step(input logic [1:0] d, input bit dv,
                         input logic [31:0] fx, input logic [31:0] fy);
    bit wall, gd, fe, was_done;
    int lat, n;
    @(negedge clk);
    step_tick = 1'b1; dir_valid = dv; dir_in = d; food_x = fx; food_y = fy;
    if (dv) model_dir(d);
    was_done = m_done;
    wall = 1'b1;
    if (!m_done) begin
      model_step(fx, fy, wall, gd, fe, lat);
      exp_q.push_back({32'(cyc + 1 + lat), gd, fe, 8'(mx.size()),
                       pack_body(1'b0), pack_body(1'b1)});
    end
    @(negedge clk);
    step_tick = 1'b0; dir_valid = 1'b0;
    chk(was_done ? "ignored_busy" : "step_busy", 32'(busy), 32'(!wall));
    n = 0;
    while (busy && n < 400) begin @(negedge clk); n++; end
    if (n >= 400) begin
      errors++;
      $display("FAIL step_timeout busy still 1 after %0d cycles, exp 0", n);
    end
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic          prev_busy = 1'b0;
  logic          prev_gd = 1'b0;
  bit            fe_follow = 1'b0;
  logic [31:0]   e_cyc;
  logic          e_gd, e_fe;
  logic [7:0]    e_len;
  logic [AW-1:0] e_x, e_y;

  always @(negedge clk) begin
    if (in_reset) begin
      fe_follow = 1'b0;
    end else if ((prev_busy && !busy) || (!prev_gd && game_done)) begin
      if (exp_q.size() == 0) begin
        errors++; checks++;
        $display("FAIL unexpected_retire got=1 exp=0 (cycle %0d)", cyc);
      end else begin
        {e_cyc, e_gd, e_fe, e_len, e_x, e_y} = exp_q.pop_front();
        chk("retire_cycle", 32'(cyc), e_cyc);
        chk("retire_game_done", 32'(game_done), 32'(e_gd));
        chk("retire_food_eaten", 32'(food_eaten), 32'(e_fe));
        chk("retire_busy", 32'(busy), 32'd0);
        chk("retire_length", 32'(length), 32'(e_len));
        chk_arr("retire_x", x_values, e_x);
        chk_arr("retire_y", y_values, e_y);
        fe_follow = !e_gd;
      end
    end else if (fe_follow) begin
      chk("food_pulse_width", 32'(food_eaten), 32'd0);
      fe_follow = 1'b0;
    end
    prev_busy = busy;
    prev_gd   = game_done;
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; step_tick = 1'b0; dir_in = 2'd1; dir_valid = 1'b0;
    food_x = '0; food_y = '0;
    repeat (2) @(negedge clk);
    apply_reset("reset");
    chk("reset_seg3_x", x_values[3*32 +: 32], 32'hFFFFFFFF);
    chk("reset_head_x", x_values[31:0], 32'd4);

    // Plain move right, food far away.
    do_step(2'd1, 1'b0, 32'd0, 32'd0);
    chk("plain_head_x", x_values[31:0], 32'd5);
    chk("plain_tail_x", x_values[2*32 +: 32], 32'd3);
    chk("plain_length", 32'(length), 32'd3);

    // Reversal rejected: left while moving right keeps going right.
    drive_dir(2'd3);
    do_step(2'd0, 1'b0, 32'd0, 32'd0);
    chk("reversal_head_x", x_values[31:0], 32'd6);
    repeat (3) do_step(2'd1, 1'b0, 32'd0, 32'd0);
    chk("edge_head_x", x_values[31:0], 32'd9);
    do_step(2'd1, 1'b0, 32'd0, 32'd0);
    chk("wall_game_done", 32'(game_done), 32'd1);
    do_step(2'd0, 1'b1, 32'd0, 32'd0);
    check_state("after_wall");

    // Growth twice, then a U-turn into the body.
    apply_reset("reset2");
    do_step(2'd1, 1'b0, 32'd5, 32'd5);
    chk("grow_length", 32'(length), 32'd4);
    chk("grow_seg3_x", x_values[3*32 +: 32], 32'd2);
    chk("grow_seg4_x", x_values[4*32 +: 32], 32'hFFFFFFFF);
    do_step(2'd1, 1'b0, 32'd6, 32'd5);
    chk("grow2_length", 32'(length), 32'd5);
    do_step(2'd0, 1'b1, 32'd0, 32'd0);
    do_step(2'd3, 1'b1, 32'd0, 32'd0);
    do_step(2'd2, 1'b1, 32'd0, 32'd0);
    chk("self_game_done", 32'(game_done), 32'd1);
    do_step(2'd1, 1'b0, 32'd0, 32'd0);
    check_state("after_self");

    // Reset while the step is in CHECK; food would have been eaten.
    apply_reset("reset3");
    @(negedge clk);
    step_tick = 1'b1; food_x = 32'd5; food_y = 32'd5;
    @(negedge clk);
    step_tick = 1'b0;
    chk("midcheck_busy", 32'(busy), 32'd1);
    apply_reset("midcheck_reset");

    // Randomized play.
    for (int it = 0; it < 250; it++) begin
      logic [1:0]  d, e;
      logic [31:0] fx, fy;
      bit          dv;
      int          r;
      if (m_done) apply_reset("rand_reset");
      if ($urandom_range(0, 5) == 0) drive_dir(2'($urandom_range(0, 3)));
      d  = 2'($urandom_range(0, 3));
      dv = 1'($urandom_range(0, 1));
      e  = (dv && d != m_cur + 2'd2) ? d : m_pend;
      r  = $urandom_range(0, 9);
      fx = mx[0]; fy = my[0];
      if (r < 4) begin
        case (e)
          2'd0: fy = fy - 1;
          2'd1: fx = fx + 1;
          2'd2: fy = fy + 1;
          default: fx = fx - 1;
        endcase
      end else if (r == 9) begin
        fx = 32'hFFFFFFFF; fy = 32'hFFFFFFFF;
      end else begin
        fx = 32'($urandom_range(0, GRID_W - 1));
        fy = 32'($urandom_range(0, GRID_H - 1));
      end
      do_step(d, dv, fx, fy);
    end

    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    errors++;
    $display("FAIL watchdog run did not finish, exp finish before %0d cycles", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
